// File: rtl/uart_sd_cmd_engine.sv
// Purpose : parses framed init/read/write commands from a UART byte stream, streams
//           write payload, issues one SD request per sector and answers every frame.
// Latency : sd_req 1 cycle after CHECK; next block 2 cycles after sd_ack; tx_valid 1 cycle after RSP0 entry.
// Backpressure: tx_data held while tx_valid && !tx_ready; rx bytes outside IDLE/HDR/WDATA are dropped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-high reset (1 = reset)
//   rx_data/rx_valid    received UART byte strobe
//   tx_data/tx_valid/tx_ready  response byte handshake (0xAA, STATUS)
//   wr_data/wr_valid    write payload byte strobe toward the SD write buffer
//   sd_req/sd_op/sd_sec SD request level with op (01 rd, 10 wr, 11 init) and sector
//   sd_ack/sd_err       SD completion strobe and error flag
//   busy                high whenever the sequencer is not idle
module uart_sd_cmd_engine #(
    parameter int SEC_W     = 32,
    parameter int CNT_W     = 8,
    parameter int BLK_BYTES = 512,
    parameter int TIMEOUT   = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       wr_data,
    output logic             wr_valid,
    output logic             sd_req,
    output logic [1:0]       sd_op,
    output logic [SEC_W-1:0] sd_sec,
    input  logic             sd_ack,
    input  logic             sd_err,
    output logic             busy
);
    localparam int SB = SEC_W / 8;
    localparam int CB = CNT_W / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLK_BYTES + 1);
    localparam logic [3:0] IDX_SEC_END = 4'(SB);
    localparam logic [3:0] IDX_CNT_END = 4'(SB + CB);

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'h01;
    localparam logic [7:0] ST_CMD = 8'h02;
    localparam logic [7:0] ST_SD  = 8'h03;
    localparam logic [7:0] ST_TMO = 8'h04;

    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_INIT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CHECK, S_WDATA, S_SDREQ, S_SDWAIT, S_NEXT, S_RSP0, S_RSP1
    } state_t;

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [7:0]       cmd_q, chk_q, xsum_q, status_q;
    logic [SEC_W-1:0] sec_q, sd_sec_q;
    logic [CNT_W-1:0] cnt_q, blk_q;
    logic [BW-1:0]    byte_q;
    logic [TW-1:0]    tmo_q;
    logic             err_q;
    logic [7:0]       tx_data_q, wr_data_q;
    logic             tx_valid_q, wr_valid_q, sd_req_q;
    logic [1:0]       sd_op_q;

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign sd_req   = sd_req_q;
    assign sd_op    = sd_op_q;
    assign sd_sec   = sd_sec_q;
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cmd_q      <= '0;
            chk_q      <= '0;
            xsum_q     <= '0;
            status_q   <= '0;
            sec_q      <= '0;
            cnt_q      <= '0;
            blk_q      <= '0;
            byte_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            sd_req_q   <= 1'b0;
            sd_op_q    <= '0;
            sd_sec_q   <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && rx_data == 8'h55) begin
                        state_q <= S_HDR;
                        idx_q   <= '0;
                        tmo_q   <= '0;
                        xsum_q  <= '0;
                    end
                end
                S_HDR: begin
                    // A byte arriving in the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        tmo_q <= '0;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == 4'd0) begin
                            cmd_q  <= rx_data;
                            xsum_q <= xsum_q ^ rx_data;
                        end else if (idx_q <= IDX_SEC_END) begin
                            sec_q  <= (sec_q << 8) | SEC_W'(rx_data);
                            xsum_q <= xsum_q ^ rx_data;
                        end else if (idx_q <= IDX_CNT_END) begin
                            cnt_q  <= (cnt_q << 8) | CNT_W'(rx_data);
                            xsum_q <= xsum_q ^ rx_data;
                        end else begin
                            chk_q   <= rx_data;
                            state_q <= S_CHECK;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        status_q <= ST_TMO;
                        state_q  <= S_RSP0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_CHECK: begin
                    blk_q <= '0;
                    if (chk_q != xsum_q) begin
                        status_q <= ST_CHK;
                        state_q  <= S_RSP0;
                    end else if (cmd_q != 8'h01 && cmd_q != 8'h02 && cmd_q != 8'h03) begin
                        status_q <= ST_CMD;
                        state_q  <= S_RSP0;
                    end else if (cmd_q == 8'h03) begin
                        // Init is a single request at sector 0 regardless of frame contents.
                        cnt_q    <= CNT_W'(1);
                        sd_op_q  <= OP_INIT;
                        sd_sec_q <= '0;
                        sd_req_q <= 1'b1;
                        state_q  <= S_SDREQ;
                    end else if (cnt_q == '0) begin
                        status_q <= ST_OK;
                        state_q  <= S_RSP0;
                    end else if (cmd_q == 8'h02) begin
                        sd_op_q  <= OP_WR;
                        sd_sec_q <= sec_q;
                        byte_q   <= '0;
                        tmo_q    <= '0;
                        state_q  <= S_WDATA;
                    end else begin
                        sd_op_q  <= OP_RD;
                        sd_sec_q <= sec_q;
                        sd_req_q <= 1'b1;
                        state_q  <= S_SDREQ;
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        tmo_q      <= '0;
                        wr_data_q  <= rx_data;
                        wr_valid_q <= 1'b1;
                        byte_q     <= byte_q + BW'(1);
                        if (byte_q == BW'(BLK_BYTES - 1)) begin
                            sd_req_q <= 1'b1;
                            state_q  <= S_SDREQ;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        status_q <= ST_TMO;
                        state_q  <= S_RSP0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_SDREQ, S_SDWAIT: begin
                    // The ack may already come in the first cycle sd_req is visible.
                    if (sd_ack) begin
                        sd_req_q <= 1'b0;
                        err_q    <= sd_err;
                        state_q  <= S_NEXT;
                    end else begin
                        state_q <= S_SDWAIT;
                    end
                end
                S_NEXT: begin
                    if (err_q) begin
                        status_q <= ST_SD;
                        state_q  <= S_RSP0;
                    end else if (blk_q + CNT_W'(1) == cnt_q) begin
                        status_q <= ST_OK;
                        state_q  <= S_RSP0;
                    end else begin
                        blk_q    <= blk_q + CNT_W'(1);
                        sd_sec_q <= sd_sec_q + SEC_W'(1);
                        if (sd_op_q == OP_WR) begin
                            byte_q  <= '0;
                            tmo_q   <= '0;
                            state_q <= S_WDATA;
                        end else begin
                            sd_req_q <= 1'b1;
                            state_q  <= S_SDREQ;
                        end
                    end
                end
                S_RSP0: begin
                    // First cycle presents the sync byte; STATUS follows its acceptance.
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'hAA;
                    end else if (tx_ready) begin
                        tx_data_q <= status_q;
                        state_q   <= S_RSP1;
                    end
                end
                S_RSP1: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sd_cmd_engine.sv
// Purpose : randomized self-checking bench for uart_sd_cmd_engine against a frame-level model.
// Latency : n/a (bench).
// Backpressure: tx_ready toggled randomly; SD responder acks after a random delay.
module tb_uart_sd_cmd_engine;
    localparam int SEC_W = 32;
    localparam int CNT_W = 8;
    localparam int BLK   = 4;
    localparam int TMO   = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             sd_req;
    logic [1:0]       sd_op;
    logic [SEC_W-1:0] sd_sec;
    logic             sd_ack;
    logic             sd_err;
    logic             busy;

    uart_sd_cmd_engine #(.SEC_W(SEC_W), .CNT_W(CNT_W), .BLK_BYTES(BLK), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .sd_req(sd_req), .sd_op(sd_op),
        .sd_sec(sd_sec), .sd_ack(sd_ack), .sd_err(sd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed traffic
    logic [7:0]  mon_tx[$];
    logic [7:0]  mon_wr[$];
    logic [1:0]  mon_op[$];
    logic [31:0] mon_sec[$];
    int          stab_bad = 0;
    logic        p_txv = 0, p_txr = 0, p_req = 0;
    logic [7:0]  p_txd = 0;
    logic [1:0]  p_op = 0;
    logic [31:0] p_sec = 0;

    always begin
        @(negedge clk);
        #1;
        if (tx_valid && tx_ready) mon_tx.push_back(tx_data);
        if (!rst_n && p_txv && !p_txr && (!tx_valid || tx_data != p_txd)) stab_bad++;
        if (wr_valid) mon_wr.push_back(wr_data);
        if (sd_req && !p_req) begin
            mon_op.push_back(sd_op);
            mon_sec.push_back(sd_sec);
        end
        if (sd_req && p_req && (sd_op != p_op || sd_sec != p_sec)) stab_bad++;
        p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data;
        p_req = sd_req; p_op = sd_op; p_sec = sd_sec;
    end

    // SD responder
    int ack_cnt  = 0;
    int err_at   = -1;
    bit hold_ack = 0;
    int dly      = 0;

    initial begin
        sd_ack = 1'b0;
        sd_err = 1'b0;
        forever begin
            @(negedge clk);
            if (sd_ack) begin
                sd_ack = 1'b0;
                sd_err = 1'b0;
            end else if (sd_req && !hold_ack) begin
                if (dly > 0) dly--;
                else begin
                    sd_ack = 1'b1;
                    sd_err = (ack_cnt == err_at);
                    ack_cnt++;
                    dly = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_mon();
        mon_tx.delete(); mon_wr.delete(); mon_op.delete(); mon_sec.delete();
        ack_cnt = 0;
    endtask

    task automatic wait_rsp(input string tag);
        int t = 0;
        while (mon_tx.size() < 2 && t < 400) begin
            @(negedge clk);
            tx_ready = ($urandom % 4) != 0;
            t++;
        end
        check({tag, "_rsp_in_time"}, t < 400, 1);
        #1;
        check({tag, "_busy_after"}, busy, 0);
        tx_ready = 1'b1;
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] st);
        check({tag, "_tx_cnt"}, mon_tx.size(), 2);
        check({tag, "_tx0"}, mon_tx.size() > 0 ? mon_tx[0] : 8'hFF, 8'hAA);
        check({tag, "_tx1"}, mon_tx.size() > 1 ? mon_tx[1] : 8'hFF, st);
    endtask

    // Drives one frame (plus payload) and checks it against the frame-level rules.
    // slow_idx/slow_gap force one inter-byte gap; a gap of TMO or more expects a timeout.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] sec,
                             input logic [7:0] cnt, input logic [7:0] chk_delta,
                             input int err_blk, input int slow_idx, input int slow_gap);
        logic [7:0]  fb[$];
        logic [1:0]  e_op[$];
        logic [31:0] e_sec[$];
        logic [7:0]  e_wr[$];
        logic [7:0]  st, chk;
        logic [1:0]  op;
        logic [31:0] base;
        int          n;
        bit          tmo;
        clear_mon();
        err_at = err_blk;
        op = 2'b00; base = '0; n = 0;
        tmo = (slow_idx > 0 && slow_gap >= TMO);
        chk = cmd ^ sec[31:24] ^ sec[23:16] ^ sec[15:8] ^ sec[7:0] ^ cnt ^ chk_delta;
        fb = '{8'h55, cmd, sec[31:24], sec[23:16], sec[15:8], sec[7:0], cnt, chk};
        if (tmo) st = 8'h04;
        else if (chk_delta != 0) st = 8'h01;
        else if (cmd != 8'h01 && cmd != 8'h02 && cmd != 8'h03) st = 8'h02;
        else if (cmd == 8'h03) begin
            op = 2'b11; n = 1; st = (err_blk == 0) ? 8'h03 : 8'h00;
        end else if (cnt == 0) st = 8'h00;
        else begin
            op   = (cmd == 8'h01) ? 2'b01 : 2'b10;
            base = sec;
            n    = (err_blk >= 0 && err_blk < int'(cnt)) ? err_blk + 1 : int'(cnt);
            st   = (err_blk >= 0 && err_blk < int'(cnt)) ? 8'h03 : 8'h00;
        end
        for (int i = 0; i < n; i++) begin
            e_op.push_back(op);
            e_sec.push_back(base + 32'(i));
        end
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], (i == slow_idx) ? slow_gap : int'($urandom_range(0, 3)));
            if (tmo && i == slow_idx) break;
        end
        if (op == 2'b10) begin
            for (int b = 0; b < n; b++) begin
                int t = 0;
                for (int k = 0; k < BLK; k++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    e_wr.push_back(d);
                    send_byte(d, (k == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2)));
                end
                while (ack_cnt <= b && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check({tag, "_blk_ack"}, t < 200, 1);
            end
        end
        wait_rsp(tag);
        check_rsp(tag, st);
        check({tag, "_req_cnt"}, mon_op.size(), e_op.size());
        for (int i = 0; i < e_op.size() && i < mon_op.size(); i++) begin
            check({tag, "_op"}, mon_op[i], e_op[i]);
            check({tag, "_sec"}, mon_sec[i], e_sec[i]);
        end
        check({tag, "_wr_cnt"}, mon_wr.size(), e_wr.size());
        for (int i = 0; i < e_wr.size() && i < mon_wr.size(); i++)
            check({tag, "_wr"}, mon_wr[i], e_wr[i]);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_sd_req", sd_req, 0);
        check("rst_sd_op", sd_op, 0);
        check("rst_sd_sec", sd_sec, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("rd2",     8'h01, 32'h10,       8'd2, 8'h00, -1, -1, 0);
        run_frame("wr1wrap", 8'h02, 32'hFFFFFFFF, 8'd1, 8'h00, -1, -1, 0);
        run_frame("wr2wrap", 8'h02, 32'hFFFFFFFF, 8'd2, 8'h00, -1, -1, 0);
        run_frame("badchk",  8'h01, 32'h1234,     8'd1, 8'h01, -1, -1, 0);
        run_frame("badcmd",  8'h07, 32'h1234,     8'd1, 8'h00, -1, -1, 0);
        run_frame("rderr",   8'h01, 32'h40,       8'd3, 8'h00,  1, -1, 0);
        run_frame("wrerr",   8'h02, 32'h80,       8'd3, 8'h00,  0, -1, 0);
        run_frame("init",    8'h03, 32'hDEAD,     8'd5, 8'h00, -1, -1, 0);
        run_frame("cnt0",    8'h01, 32'h5,        8'd0, 8'h00, -1, -1, 0);
        run_frame("gap_ok",  8'h01, 32'h7,        8'd1, 8'h00, -1,  2, TMO - 1);
        run_frame("gap_tmo", 8'h01, 32'h7,        8'd1, 8'h00, -1,  2, TMO);

        // Frame halted after its third byte, with the transmitter stalled.
        clear_mon();
        tx_ready = 1'b0;
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        t = 0;
        while (!tx_valid && t < TMO + 20) begin
            @(negedge clk);
            t++;
        end
        check("halt_tx_valid_in_time", t < TMO + 20, 1);
        repeat (5) begin
            @(negedge clk);
            tx_ready = 1'b0;
            #1;
            check("halt_stall_data", tx_data, 8'hAA);
        end
        wait_rsp("halt");
        check_rsp("halt", 8'h04);
        check("halt_req_cnt", mon_op.size(), 0);

        // Reset in the middle of an SD wait, then a stray ack.
        clear_mon();
        hold_ack = 1;
        send_byte(8'h55, 1);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'h02, 0);
        send_byte(8'h01 ^ 8'h20 ^ 8'h02, 0);
        t = 0;
        while (!sd_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_rst_req_seen", t < 50, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sd_req", sd_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_sd_op", sd_op, 0);
        check("mid_rst_sd_sec", sd_sec, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        sd_ack = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("stray_ack_busy", busy, 0);
        check("stray_ack_sd_req", sd_req, 0);
        check("stray_ack_tx", mon_tx.size(), 0);
        hold_ack = 0;
        run_frame("after_rst", 8'h01, 32'h99, 8'd1, 8'h00, -1, -1, 0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0]  cmd, cnt, dl;
            logic [31:0] sec;
            int          r, eb;
            r   = $urandom_range(0, 7);
            cmd = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : (r == 6) ? 8'h03 : 8'($urandom_range(4, 255));
            cnt = 8'($urandom_range(0, 3));
            sec = ($urandom % 4 == 0) ? 32'hFFFFFFFE : $urandom;
            dl  = ($urandom % 8 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            eb  = ($urandom % 3 == 0) ? int'($urandom_range(0, 2)) : -1;
            run_frame("rnd", cmd, sec, cnt, dl, eb, -1, 0);
        end

        check("stability", stab_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
